// File: rtl/counter_pkg.sv
// Shared types for the counter sample-buffer readout controller.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } readout_state_t;

  // Fill counter needs one extra bit so that a completely full buffer (DEPTH)
  // is distinguishable from an empty one.
  function automatic int fill_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/counter_readout.sv
// Pointer and readout controller for the dual-channel counter sample buffer.
// Channel A (write) is addressed by wr_ptr, channel B (read) by rd_ptr; pops
// are served oldest-first through a strobe/ack handshake with 2-cycle latency.
// Optional macro COUNTER_READOUT_WATERMARK_EN adds a fill-level watermark flag.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no pop in flight; rd_ptr stable so the SRAM can sample it
// FETCH | SRAM read data valid; capture sample (or empty marker), advance
// RESP  | o_rd_ack high for this single cycle
module counter_readout
  import counter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4096
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_wr_valid,
  output logic                      o_wr_en,
  output logic [ADDR_WIDTH-1:0]     o_wr_addr,
  input  logic                      i_rd_req,
  output logic                      o_rd_ack,
  output logic [DATA_WIDTH-1:0]     o_rd_data,
  output logic                      o_rd_empty,
  output logic [ADDR_WIDTH-1:0]     o_sram_addr,
  input  logic [DATA_WIDTH-1:0]     i_sram_data,
  input  logic                      i_clear,
`ifdef COUNTER_READOUT_WATERMARK_EN
  input  logic [ADDR_WIDTH:0]       i_watermark,
  output logic                      o_watermark,
`endif
  output logic [ADDR_WIDTH:0]       o_fill,
  output logic                      o_overflow
);

  localparam int FILL_W = fill_width(ADDR_WIDTH);

  readout_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic                    overflow_q, overflow_d;
  logic                    was_empty_q, was_empty_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    rd_empty_q, rd_empty_d;
  logic                    full;
  logic                    empty;
  logic                    wr_en;
  logic                    pop;

  // Next-state logic for the readout FSM, pointers, fill level and overflow.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fill_d      = fill_q;
    overflow_d  = overflow_q;
    was_empty_d = was_empty_q;
    rd_data_d   = rd_data_q;
    rd_empty_d  = rd_empty_q;
    pop         = 1'b0;

    full  = (fill_q == FILL_W'(DEPTH));
    empty = (fill_q == '0);
    wr_en = i_wr_valid & ~full;

    case (state_q)
      IDLE: begin
        if (i_rd_req) begin
          state_d = FETCH;
          // A clear on the accepting edge empties the buffer, so the response
          // must report empty.
          was_empty_d = empty | i_clear;
        end
      end
      FETCH: begin
        state_d = RESP;
        if (!was_empty_q && !i_clear) begin
          pop        = 1'b1;
          rd_data_d  = i_sram_data;
          rd_empty_d = 1'b0;
        end else begin
          rd_data_d  = '0;
          rd_empty_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // DEPTH is a power of two, so natural pointer overflow implements the wrap.
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    if (wr_en && !pop) begin
      fill_d = fill_q + FILL_W'(1);
    end else if (pop && !wr_en) begin
      fill_d = fill_q - FILL_W'(1);
    end

    // Full is judged on the pre-edge fill, so a write alongside a pop from
    // full is still dropped.
    if (i_wr_valid && full) begin
      overflow_d = 1'b1;
    end

    if (i_clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      overflow_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      was_empty_q <= 1'b0;
      rd_data_q   <= '0;
      rd_empty_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      was_empty_q <= was_empty_d;
      rd_data_q   <= rd_data_d;
      rd_empty_q  <= rd_empty_d;
    end
  end

`ifdef COUNTER_READOUT_WATERMARK_EN
  logic watermark_q, watermark_d;

  // Watermark flag follows the registered fill level; zero threshold disables it.
  always_comb begin
    watermark_d = (i_watermark != '0) && (fill_q >= i_watermark);
  end

  // Watermark register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      watermark_q <= 1'b0;
    end else begin
      watermark_q <= watermark_d;
    end
  end

  assign o_watermark = watermark_q;
`endif

  assign o_wr_en     = wr_en;
  assign o_wr_addr   = wr_ptr_q;
  assign o_sram_addr = rd_ptr_q;
  assign o_rd_ack    = (state_q == RESP);
  assign o_rd_data   = rd_data_q;
  assign o_rd_empty  = rd_empty_q;
  assign o_fill      = fill_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_counter_readout.sv
// Directed bench for counter_readout with a behavioural buffer SRAM, a
// reference FIFO of written samples and a queue of expected pop responses.
module tb_counter_readout;

  localparam int AW    = 12;
  localparam int DW    = 18;
  localparam int DEPTH = 4096;

  typedef struct packed {
    logic          empty;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          rd_req;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_empty;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_q;
  logic          clear;
  logic [AW:0]   fill;
  logic          overflow;
  logic [DW-1:0] wr_data;
`ifdef COUNTER_READOUT_WATERMARK_EN
  logic [AW:0]   watermark_thr;
  logic          watermark;
`endif

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] model[$];
  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  counter_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .i_rd_req    (rd_req),
    .o_rd_ack    (rd_ack),
    .o_rd_data   (rd_data),
    .o_rd_empty  (rd_empty),
    .o_sram_addr (sram_addr),
    .i_sram_data (sram_q),
    .i_clear     (clear),
`ifdef COUNTER_READOUT_WATERMARK_EN
    .i_watermark (watermark_thr),
    .o_watermark (watermark),
`endif
    .o_fill      (fill),
    .o_overflow  (overflow)
  );

  // Buffer SRAM: channel A writes, channel B registered read.
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    sram_q <= mem[sram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_samples(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(seed + i * 37);
      if (model.size() < DEPTH) model.push_back(wr_data);
      step();
    end
    wr_valid = 1'b0;
  endtask

  // Drive the strobe for one cycle and record the expected response.
  task automatic pop_issue();
    exp_t e;
    if (model.size() == 0) begin
      e.empty = 1'b1;
      e.data  = '0;
    end else begin
      e.empty = 1'b0;
      e.data  = model.pop_front();
    end
    exp_q.push_back(e);
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
  endtask

  // Wait (bounded) for the ack and compare against the scoreboard head.
  task automatic pop_collect(input string tag, input int start_cycles);
    int   cycles;
    exp_t e;
    cycles = start_cycles;
    while (!rd_ack && cycles < 8) begin
      step();
      cycles++;
    end
    chk({tag, "_ack"}, 32'(rd_ack), 32'd1);
    chk({tag, "_latency"}, 32'(cycles), 32'd2);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_underrun"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_empty"}, 32'(rd_empty), 32'(e.empty));
      chk({tag, "_data"}, 32'(rd_data), 32'(e.data));
    end
    chk({tag, "_fill"}, 32'(fill), 32'(model.size()));
    step();
    chk({tag, "_ack_one_cycle"}, 32'(rd_ack), 32'd0);
  endtask

  task automatic pop(input string tag);
    pop_issue();
    pop_collect(tag, 1);
  endtask

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    clear    = 1'b0;
    wr_data  = '0;
`ifdef COUNTER_READOUT_WATERMARK_EN
    watermark_thr = '0;
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_ack", 32'(rd_ack), 32'd0);
    chk("rst_empty", 32'(rd_empty), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_fill", 32'(fill), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);

    // Pop from empty buffer
    pop("empty_pop");

    // Three samples, popped in order, then one more pop from empty
    write_samples(1, 32'h00011);
    write_samples(1, 32'h00022);
    write_samples(1, 32'h00033);
    chk("three_fill", 32'(fill), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("three_sram_addr", 32'(sram_addr), 32'(i));
      pop("three_pop");
    end
    pop("fourth_pop_empty");

    // Clear in IDLE returns pointers to 0
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_idle_wr_addr", 32'(wr_addr), 32'd0);
    chk("clr_idle_sram_addr", 32'(sram_addr), 32'd0);
    chk("clr_idle_fill", 32'(fill), 32'd0);

    // Fill completely, then one extra write is dropped
    write_samples(DEPTH, 100);
    chk("full_fill", 32'(fill), 32'(DEPTH));
    chk("full_wr_addr_wrapped", 32'(wr_addr), 32'd0);
    chk("full_no_overflow_yet", 32'(overflow), 32'd0);
    wr_valid = 1'b1;
    wr_data  = DW'(32'h3ffff);
    #1;
    chk("extra_wr_en", 32'(wr_en), 32'd0);
    step();
    wr_valid = 1'b0;
    chk("extra_overflow", 32'(overflow), 32'd1);
    chk("extra_fill", 32'(fill), 32'(DEPTH));
    chk("extra_wr_addr", 32'(wr_addr), 32'd0);

    pop("pop_from_full");
    chk("pop_from_full_fill", 32'(fill), 32'(DEPTH - 1));
    chk("overflow_sticky", 32'(overflow), 32'd1);

    // Drain the rest; rd_ptr wraps back to 0
    for (int i = 1; i < DEPTH; i++) pop("drain");
    chk("drain_fill", 32'(fill), 32'd0);
    chk("drain_sram_addr", 32'(sram_addr), 32'd0);

    // Two writes after the wrap
    chk("wrap_wr_addr0", 32'(wr_addr), 32'd0);
    write_samples(1, 32'h1234);
    chk("wrap_wr_addr1", 32'(wr_addr), 32'd1);
    write_samples(1, 32'h2345);
    chk("wrap_wr_addr2", 32'(wr_addr), 32'd2);
    chk("wrap_sram_addr0", 32'(sram_addr), 32'd0);
    pop("wrap_pop0");
    chk("wrap_sram_addr1", 32'(sram_addr), 32'd1);
    pop("wrap_pop1");
    chk("wrap_sram_addr2", 32'(sram_addr), 32'd2);

    // Write coinciding with the pop capture edge at fill=5
    write_samples(5, 32'h500);
    chk("sim_fill_before", 32'(fill), 32'd5);
    chk("sim_wr_addr_before", 32'(wr_addr), 32'd7);
    pop_issue();
    wr_valid = 1'b1;
    wr_data  = DW'(32'h0abcd);
    model.push_back(wr_data);
    step();
    wr_valid = 1'b0;
    chk("sim_fill_after", 32'(fill), 32'd5);
    chk("sim_wr_addr_after", 32'(wr_addr), 32'd8);
    chk("sim_sram_addr_after", 32'(sram_addr), 32'd3);
    pop_collect("sim_pop", 2);

    // Clear during FETCH at fill=10 forces an empty response
    write_samples(5, 32'h700);
    chk("clr_fill_before", 32'(fill), 32'd10);
    chk("clr_overflow_before", 32'(overflow), 32'd1);
    begin
      exp_t e;
      e.empty = 1'b1;
      e.data  = '0;
      exp_q.push_back(e);
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    clear  = 1'b1;
    model.delete();
    step();
    clear = 1'b0;
    chk("clr_fill", 32'(fill), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd0);
    chk("clr_wr_addr", 32'(wr_addr), 32'd0);
    chk("clr_sram_addr", 32'(sram_addr), 32'd0);
    pop_collect("clr_fetch_pop", 2);

`ifdef COUNTER_READOUT_WATERMARK_EN
    watermark_thr = 13'd4;
    step();
    chk("wm_low", 32'(watermark), 32'd0);
    write_samples(4, 32'h900);
    chk("wm_not_yet", 32'(watermark), 32'd0);
    step();
    chk("wm_rise", 32'(watermark), 32'd1);
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_readout.md
Name: counter_readout

Overview:
- Pointer and readout controller for the dual-channel counter sample buffer.
- Owns the write pointer that addresses buffer channel A for the counter, and the read pointer that drives buffer channel B.
- Drains samples oldest-first to the system bus through a strobe/ack pop interface.
- Tracks fill level and a sticky overflow flag; its parent instantiates it next to the buffer SRAM.

Parameters:
ADDR_WIDTH, 12, buffer address width
DATA_WIDTH, 18, sample width
DEPTH, 4096, buffer entries; must equal 2**ADDR_WIDTH

Ports:
i_clk  in  1  single clock for the whole block
i_rst  in  1  synchronous reset, active-high
i_wr_valid  in  1  counter has a new sample this cycle
o_wr_en  out  1  buffer channel A write enable = i_wr_valid & !full (combinational)
o_wr_addr  out  ADDR_WIDTH  buffer channel A address = wr_ptr
i_rd_req  in  1  bus pop strobe, one cycle
o_rd_ack  out  1  one-cycle pop response
o_rd_data  out  DATA_WIDTH  popped sample, valid when o_rd_ack is high
o_rd_empty  out  1  qualifies o_rd_ack: 1 means no sample returned
o_sram_addr  out  ADDR_WIDTH  buffer channel B address = rd_ptr
i_sram_data  in  DATA_WIDTH  buffer channel B registered read data (1-cycle latency)
i_clear  in  1  software clear of pointers, fill and overflow
o_fill  out  ADDR_WIDTH+1  stored sample count, 0..DEPTH
o_overflow  out  1  sticky: a sample was dropped because the buffer was full

Behaviour:
- Reset values: all outputs 0; wr_ptr=0, rd_ptr=0, fill=0; FSM in IDLE.
- full is fill==DEPTH; empty is fill==0.
- Write path, on o_wr_en:
  - wr_ptr increments, wrapping DEPTH-1 -> 0.
  - fill increments.
- i_wr_valid while full: no write, pointers unchanged, o_overflow set to 1 (sticky).
- FSM states: IDLE, FETCH, RESP.
  - IDLE: when i_rd_req=1, go to FETCH and latch was_empty=empty. rd_ptr is stable, so the SRAM samples o_sram_addr at this edge.
  - FETCH: unconditionally go to RESP.
    - If was_empty=0: o_rd_data <= i_sram_data; rd_ptr++ (wraps); fill--; o_rd_empty <= 0.
    - If was_empty=1: o_rd_data <= 0; o_rd_empty <= 1.
  - RESP: o_rd_ack=1 for exactly this cycle, then IDLE.
- Latency: strobe in cycle 0 gives ack in cycle 2. At most one pop in flight; i_rd_req in FETCH or RESP is ignored.
- o_rd_data and o_rd_empty hold their values until the next FETCH.
- Simultaneous write and pop on the same edge: fill is unchanged and both pointers advance.
- A pop from full on the same edge as i_wr_valid: write is dropped and overflow is set, because full is evaluated pre-edge.
- Read/write address collision cannot occur for a valid pop. A read when fill>0 and not full has rd_ptr != wr_ptr. When full, writes are gated off.
- i_clear, with priority over write and pop updates:
  - Sets wr_ptr=0, rd_ptr=0, fill=0, overflow=0.
  - If the FSM is in FETCH that cycle, or in IDLE accepting a strobe, the pending response is forced to o_rd_empty=1 with data 0.
  - The ack still occurs, so the bus never hangs.
- i_rst mid-pop: FSM returns to IDLE and no ack is produced; the bus master's own reset covers this.

Optional Feature:
- Macro COUNTER_READOUT_WATERMARK_EN.
- Defined:
  - Adds input i_watermark (ADDR_WIDTH+1) and output o_watermark.
  - o_watermark is registered, reset 0, and equals 1 when fill >= i_watermark and i_watermark != 0, updated every cycle.
  - This lets software interrupt-drive bulk reads.
- Undefined: neither port exists and the behaviour is otherwise identical.

Decomposition:
- Package counter_pkg holds:
  - typedef enum logic [1:0] {IDLE, FETCH, RESP} readout_state_t
  - localparam-derived fill width helper (ADDR_WIDTH+1)
- No sub-module: the pointer/fill logic and the 3-state FSM are small enough to live in one module. The buffer SRAM is instantiated by the parent.

Test Plan:
- Reset, then pop with empty buffer: i_rd_req at cycle 0 -> o_rd_ack in cycle 2 with o_rd_empty=1, o_rd_data=0, o_fill=0.
- Write 3 samples (0x00011, 0x00022, 0x00033) via i_wr_valid, then 3 pops -> data returned in order, o_fill 3->0, o_sram_addr 0,1,2, 4th pop returns empty.
- Fill all 4096 entries plus 1 extra i_wr_valid -> o_wr_en=0 on the extra, o_overflow=1, o_fill=4096; one pop -> o_fill=4095, overflow stays 1.
- Pointer wrap: 4096 writes, 4096 pops, then 2 writes -> o_wr_addr 0->1->2, pops read addresses 0 and 1 with correct data.
- Simultaneous i_wr_valid and pop capture edge at fill=5 -> o_fill stays 5, both pointers advance by 1.
- i_clear asserted during FETCH with fill=10 -> ack in cycle 2 with o_rd_empty=1, data 0; o_fill=0, o_overflow=0, pointers 0. With COUNTER_READOUT_WATERMARK_EN, i_watermark=4: o_watermark rises the cycle after the 4th write.
